// File: rtl/bp_sacc_vdp_mc.sv
`default_nettype none
// ============================================================================
// Module   : bp_sacc_vdp_mc
// Purpose  : Multi-channel lane-parallel dot-product / sum engine behind an
//            MMIO command/response port. Optional: BP_SACC_VDP_MC_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bp_sacc_vdp_mc #(
    parameter int channels_p   = 2,
    parameter int lanes_p      = 4,
    parameter int vec_depth_p  = 16,
    parameter int data_width_p = 64,
    parameter int addr_width_p = 20
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      io_cmd_v_i,
    output logic                      io_cmd_ready_o,
    input  logic                      io_cmd_w_i,
    input  logic [addr_width_p-1:0]   io_cmd_addr_i,
    input  logic [data_width_p-1:0]   io_cmd_data_i,
    output logic                      io_resp_v_o,
    input  logic                      io_resp_yumi_i,
    output logic [data_width_p-1:0]   io_resp_data_o,
    output logic [channels_p-1:0]     done_o
);

    localparam int DW      = data_width_p;
    localparam int CH_W    = (channels_p > 1) ? $clog2(channels_p) : 1;
    localparam int DEPTH_W = (vec_depth_p > 1) ? $clog2(vec_depth_p) : 1;
    localparam int IDX_W   = $clog2(vec_depth_p + lanes_p) + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    logic [DW-1:0]         a_q      [channels_p][vec_depth_p];
    logic [DW-1:0]         b_q      [channels_p][vec_depth_p];
    logic [DW-1:0]         len_q    [channels_p];
    logic [DW-1:0]         result_q [channels_p];
`ifdef BP_SACC_VDP_MC_PERF_CNT_EN
    logic [31:0]           cycles_q [channels_p];
`endif
    logic [channels_p-1:0] busy_q, done_q, err_q, mode_q, pend_q;

    state_e                state_q;
    logic [CH_W-1:0]       cur_q, last_q;
    logic [IDX_W-1:0]      idx_q, len_eff_q;
    logic [DW-1:0]         acc_q;

    logic                  resp_v_q;
    logic [DW-1:0]         resp_data_q;

    // ---------------- address decode ----------------
    logic                  w_accept, w_wr, w_blocked;
    logic [CH_W-1:0]       w_ch;
    logic                  w_ch_ok;
    logic [8:0]            w_reg;
    logic [6:0]            w_opi;
    logic [DEPTH_W-1:0]    w_el;
    logic                  w_op_ok;
    logic                  w_is_ctrl, w_is_len, w_is_stat, w_is_res, w_is_cyc, w_is_a, w_is_b;
    logic                  w_unused_addr;

    assign w_accept = io_cmd_v_i & ~resp_v_q;

    generate
        if (channels_p > 1) begin : g_ch_multi
            assign w_ch    = io_cmd_addr_i[12 +: CH_W];
            assign w_ch_ok = int'(w_ch) < channels_p;
        end else begin : g_ch_single
            assign w_ch    = '0;
            assign w_ch_ok = 1'b1;
        end
    endgenerate

    assign w_unused_addr = ^{io_cmd_addr_i[2:0], io_cmd_addr_i[addr_width_p-1:12]};

    assign w_reg     = io_cmd_addr_i[11:3];
    assign w_opi     = io_cmd_addr_i[9:3];
    assign w_el      = io_cmd_addr_i[3 +: DEPTH_W];
    assign w_op_ok   = int'(w_opi) < vec_depth_p;
    assign w_is_ctrl = (w_reg == 9'h000);
    assign w_is_len  = (w_reg == 9'h001);
    assign w_is_stat = (w_reg == 9'h002);
    assign w_is_res  = (w_reg == 9'h003);
    assign w_is_cyc  = (w_reg == 9'h004);
    assign w_is_a    = (io_cmd_addr_i[11:10] == 2'b01) & w_op_ok;
    assign w_is_b    = (io_cmd_addr_i[11:10] == 2'b10) & w_op_ok;

    assign w_wr      = w_accept & io_cmd_w_i & w_ch_ok;
    assign w_blocked = busy_q[w_ch] & (w_is_ctrl | w_is_len | w_is_a | w_is_b);

    logic [DW-1:0] w_rdata;
    always_comb begin
        w_rdata = '0;
        if (w_ch_ok) begin
            if (w_is_len)       w_rdata = len_q[w_ch];
            else if (w_is_stat) w_rdata = {{(DW-3){1'b0}}, err_q[w_ch], done_q[w_ch], busy_q[w_ch]};
            else if (w_is_res)  w_rdata = result_q[w_ch];
`ifdef BP_SACC_VDP_MC_PERF_CNT_EN
            else if (w_is_cyc)  w_rdata = DW'(cycles_q[w_ch]);
`endif
            else if (w_is_a)    w_rdata = a_q[w_ch][w_el];
            else if (w_is_b)    w_rdata = b_q[w_ch][w_el];
        end
    end

    // ---------------- round-robin grant ----------------
    logic            w_found;
    logic [CH_W-1:0] w_grant, w_cand;
    logic [DW-1:0]   w_len_sel;
    logic [IDX_W-1:0] w_len_eff;

    always_comb begin
        w_found = 1'b0;
        w_grant = last_q;
        w_cand  = '0;
        for (int k = 1; k <= channels_p; k++) begin
            w_cand = CH_W'((int'(last_q) + k) % channels_p);
            if (!w_found && pend_q[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
        w_len_sel = len_q[w_grant];
        if (w_len_sel > DW'(vec_depth_p)) w_len_eff = IDX_W'(vec_depth_p);
        else                              w_len_eff = w_len_sel[IDX_W-1:0];
    end

    // ---------------- lane datapath ----------------
    logic [IDX_W-1:0] w_lane_idx, w_next_idx;
    logic [DW-1:0]    w_chunk;
    logic             w_last;

    always_comb begin
        w_chunk    = '0;
        w_lane_idx = '0;
        for (int l = 0; l < lanes_p; l++) begin
            w_lane_idx = idx_q + IDX_W'(l);
            if (w_lane_idx < len_eff_q) begin
                if (mode_q[cur_q])
                    w_chunk = w_chunk + a_q[cur_q][w_lane_idx[DEPTH_W-1:0]];
                else
                    w_chunk = w_chunk + (a_q[cur_q][w_lane_idx[DEPTH_W-1:0]] *
                                         b_q[cur_q][w_lane_idx[DEPTH_W-1:0]]);
            end
        end
    end

    assign w_next_idx = idx_q + IDX_W'(lanes_p);
    assign w_last     = (w_next_idx >= len_eff_q);

    // ---------------- channel state + engine FSM ----------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < channels_p; c++) begin
                for (int i = 0; i < vec_depth_p; i++) begin
                    a_q[c][i] <= '0;
                    b_q[c][i] <= '0;
                end
                len_q[c]    <= '0;
                result_q[c] <= '0;
`ifdef BP_SACC_VDP_MC_PERF_CNT_EN
                cycles_q[c] <= '0;
`endif
            end
            busy_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
            mode_q    <= '0;
            pend_q    <= '0;
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            last_q    <= '0;
            idx_q     <= '0;
            len_eff_q <= '0;
            acc_q     <= '0;
        end else begin
`ifdef BP_SACC_VDP_MC_PERF_CNT_EN
            for (int c = 0; c < channels_p; c++) begin
                if (busy_q[c] && (cycles_q[c] != 32'hFFFF_FFFF))
                    cycles_q[c] <= cycles_q[c] + 32'd1;
            end
`endif
            if (w_wr) begin
                if (w_blocked) begin
                    err_q[w_ch] <= 1'b1;
                end else begin
                    if (w_is_a)   a_q[w_ch][w_el] <= io_cmd_data_i;
                    if (w_is_b)   b_q[w_ch][w_el] <= io_cmd_data_i;
                    if (w_is_len) len_q[w_ch]     <= io_cmd_data_i;
                    if (w_is_ctrl && io_cmd_data_i[0]) begin
                        busy_q[w_ch] <= 1'b1;
                        pend_q[w_ch] <= 1'b1;
                        done_q[w_ch] <= 1'b0;
                        err_q[w_ch]  <= 1'b0;
                        mode_q[w_ch] <= io_cmd_data_i[1];
`ifdef BP_SACC_VDP_MC_PERF_CNT_EN
                        cycles_q[w_ch] <= '0;
`endif
                    end
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_found) begin
                        pend_q[w_grant] <= 1'b0;
                        cur_q           <= w_grant;
                        last_q          <= w_grant;
                        idx_q           <= '0;
                        acc_q           <= '0;
                        len_eff_q       <= w_len_eff;
                        state_q         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    idx_q <= w_next_idx;
                    acc_q <= acc_q + w_chunk;
                    if (w_last) begin
                        result_q[cur_q] <= acc_q + w_chunk;
                        done_q[cur_q]   <= 1'b1;
                        busy_q[cur_q]   <= 1'b0;
                        state_q         <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ---------------- response channel ----------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_v_q    <= 1'b0;
            resp_data_q <= '0;
        end else if (w_accept) begin
            resp_v_q    <= 1'b1;
            resp_data_q <= io_cmd_w_i ? '0 : w_rdata;
        end else if (io_resp_yumi_i) begin
            resp_v_q    <= 1'b0;
            resp_data_q <= '0;
        end
    end

    assign io_cmd_ready_o = ~resp_v_q;
    assign io_resp_v_o    = resp_v_q;
    assign io_resp_data_o = resp_data_q;
    assign done_o         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_sacc_vdp_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_sacc_vdp_mc
// Purpose  : Scoreboard bench for bp_sacc_vdp_mc (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_sacc_vdp_mc;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        io_cmd_v_i = 1'b0;
    logic        io_cmd_ready_o;
    logic        io_cmd_w_i = 1'b0;
    logic [19:0] io_cmd_addr_i = '0;
    logic [63:0] io_cmd_data_i = '0;
    logic        io_resp_v_o;
    logic        io_resp_yumi_i = 1'b0;
    logic [63:0] io_resp_data_o;
    logic [1:0]  done_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [63:0] exp_q[$];
    string       name_q[$];
    bit          hold_yumi = 1'b0;
    logic [63:0] m_exp;
    string       m_nm;

    localparam logic [11:0] OFF_CTRL = 12'h000;
    localparam logic [11:0] OFF_LEN  = 12'h008;
    localparam logic [11:0] OFF_STAT = 12'h010;
    localparam logic [11:0] OFF_RES  = 12'h018;
    localparam logic [11:0] OFF_CYC  = 12'h020;
`ifdef BP_SACC_VDP_MC_PERF_CNT_EN
    localparam logic [63:0] EXP_CYC = 64'd3;
`else
    localparam logic [63:0] EXP_CYC = 64'd0;
`endif

    bp_sacc_vdp_mc dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .io_cmd_v_i     (io_cmd_v_i),
        .io_cmd_ready_o (io_cmd_ready_o),
        .io_cmd_w_i     (io_cmd_w_i),
        .io_cmd_addr_i  (io_cmd_addr_i),
        .io_cmd_data_i  (io_cmd_data_i),
        .io_resp_v_o    (io_resp_v_o),
        .io_resp_yumi_i (io_resp_yumi_i),
        .io_resp_data_o (io_resp_data_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Issue one command; returns one step after the accept edge.
    task automatic cmd(input logic w, input logic ch, input logic [11:0] off,
                       input logic [63:0] d, input logic [63:0] e, input string nm);
        int n = 0;
        io_cmd_v_i    = 1'b1;
        io_cmd_w_i    = w;
        io_cmd_addr_i = {7'd0, ch, off};
        io_cmd_data_i = d;
        while (!io_cmd_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!io_cmd_ready_o) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: got ready=0 expected ready=1", nm);
            io_cmd_v_i = 1'b0;
            return;
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk_i); #1;
        io_cmd_v_i = 1'b0;
    endtask

    task automatic wr(input logic ch, input logic [11:0] off, input logic [63:0] d);
        cmd(1'b1, ch, off, d, 64'd0, "wr_ack");
    endtask

    task automatic rd(input logic ch, input logic [11:0] off, input logic [63:0] e, input string nm);
        cmd(1'b0, ch, off, 64'd0, e, nm);
    endtask

    task automatic start(input logic ch, input logic [63:0] ctrl, output int t0);
        wr(ch, OFF_CTRL, ctrl);
        t0 = cyc;
    endtask

    task automatic wait_done(input logic ch, output int t);
        int n = 0;
        while (!done_o[ch] && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!done_o[ch]) begin
            checks++;
            errors++;
            $display("FAIL done_timeout ch%0d: got done=0 expected done=1", ch);
        end
        t = cyc;
    endtask

    // Monitor: pops expected value whenever the DUT presents a response.
    initial begin
        forever begin
            @(negedge clk_i);
            if (io_resp_v_o === 1'b1 && !hold_yumi) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got 0x%0h expected no response", io_resp_data_o);
                end else begin
                    m_exp = exp_q.pop_front();
                    m_nm  = name_q.pop_front();
                    check(m_nm, io_resp_data_o, m_exp);
                end
                io_resp_yumi_i = 1'b1;
                @(posedge clk_i); #1;
                io_resp_yumi_i = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, tx, t;
        int n;

        // Reset values
        #12;
        check("rst_ready", 64'(io_cmd_ready_o), 64'd1);
        check("rst_resp_v", 64'(io_resp_v_o), 64'd0);
        check("rst_resp_data", io_resp_data_o, 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        @(posedge clk_i); #3;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Dot product ch0: A=1..8, B=2 -> 72
        for (int i = 0; i < 8; i++) begin
            wr(1'b0, 12'h400 + 12'(8 * i), 64'(i + 1));
            wr(1'b0, 12'h800 + 12'(8 * i), 64'd2);
        end
        wr(1'b0, OFF_LEN, 64'd8);
        start(1'b0, 64'd1, t0);
        wait_done(1'b0, t);
        check("dot_latency", 64'(t - t0), 64'd3);
        rd(1'b0, OFF_RES, 64'd72, "dot_result");
        rd(1'b0, OFF_STAT, 64'd2, "dot_status");

        // Sum mode ch1: A=1..5 -> 15, B ignored
        for (int i = 0; i < 5; i++) begin
            wr(1'b1, 12'h400 + 12'(8 * i), 64'(i + 1));
            wr(1'b1, 12'h800 + 12'(8 * i), 64'(100 + i));
        end
        wr(1'b1, OFF_LEN, 64'd5);
        start(1'b1, 64'd3, t0);
        wait_done(1'b1, t);
        check("sum_latency", 64'(t - t0), 64'd3);
        rd(1'b1, OFF_RES, 64'd15, "sum_result");
        rd(1'b1, 12'h410, 64'd3, "readback_a1_2");
        rd(1'b1, 12'h800, 64'd100, "readback_b1_0");
        rd(1'b1, OFF_LEN, 64'd5, "readback_len1");

        // Write to busy channel is dropped and flags err
        wr(1'b0, OFF_LEN, 64'd16);
        start(1'b0, 64'd1, t0);
        wr(1'b0, 12'h400, 64'd99);
        rd(1'b0, OFF_STAT, 64'd5, "busy_status");
        wait_done(1'b0, t);
        check("len16_latency", 64'(t - t0), 64'd5);
        rd(1'b0, 12'h400, 64'd1, "dropped_write");
        rd(1'b0, OFF_RES, 64'd72, "len16_result");
        rd(1'b0, OFF_STAT, 64'd6, "err_done_status");

        // Round robin: ch0 (16) then ch1 (4, sum); restart on busy ch0 -> err
        wr(1'b1, OFF_LEN, 64'd4);
        start(1'b0, 64'd1, t0);
        start(1'b1, 64'd3, t1);
        start(1'b0, 64'd1, tx);
        wait_done(1'b0, t);
        check("rr_ch0_latency", 64'(t - t0), 64'd5);
        wait_done(1'b1, t);
        check("rr_ch1_latency", 64'(t - t0), 64'd7);
        rd(1'b0, OFF_RES, 64'd72, "rr_result0");
        rd(1'b1, OFF_RES, 64'd10, "rr_result1");
        rd(1'b0, OFF_STAT, 64'd6, "busy_start_status");
        rd(1'b1, OFF_STAT, 64'd2, "rr_status1");

        // LEN = 0
        wr(1'b1, OFF_LEN, 64'd0);
        start(1'b1, 64'd1, t0);
        wait_done(1'b1, t);
        check("len0_latency", 64'(t - t0), 64'd2);
        rd(1'b1, OFF_RES, 64'd0, "len0_result");

        // LEN = 40 clamps to 16
        wr(1'b0, 12'h478, 64'd5);
        wr(1'b0, 12'h878, 64'd3);
        wr(1'b0, OFF_LEN, 64'd40);
        start(1'b0, 64'd1, t0);
        wait_done(1'b0, t);
        check("clamp_latency", 64'(t - t0), 64'd5);
        rd(1'b0, OFF_RES, 64'd87, "clamp_result");
        rd(1'b0, OFF_LEN, 64'd40, "clamp_len_reg");

        // Wrap: all-ones squared -> 1
        wr(1'b1, 12'h400, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(1'b1, 12'h800, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(1'b1, OFF_LEN, 64'd1);
        start(1'b1, 64'd1, t0);
        wait_done(1'b1, t);
        check("wrap_latency", 64'(t - t0), 64'd2);
        rd(1'b1, OFF_RES, 64'd1, "wrap_result");

        // Cycle counter
        wr(1'b0, OFF_LEN, 64'd8);
        start(1'b0, 64'd1, t0);
        wait_done(1'b0, t);
        check("cyc_latency", 64'(t - t0), 64'd3);
        rd(1'b0, OFF_RES, 64'd72, "cyc_job_result");
        rd(1'b0, OFF_CYC, EXP_CYC, "cycles");

        // Backpressure: response held 5 cycles
        n = 0;
        while ((exp_q.size() != 0 || io_resp_v_o) && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        hold_yumi = 1'b1;
        rd(1'b0, OFF_RES, 64'd72, "bp_result");
        for (int k = 0; k < 5; k++) begin
            check("bp_ready", 64'(io_cmd_ready_o), 64'd0);
            check("bp_resp_v", 64'(io_resp_v_o), 64'd1);
            check("bp_data", io_resp_data_o, 64'd72);
            @(posedge clk_i); #1;
        end
        hold_yumi = 1'b0;

        // Unmapped accesses
        wr(1'b0, 12'h300, 64'hDEAD);
        rd(1'b0, 12'h300, 64'd0, "unmapped_300");
        rd(1'b0, 12'h028, 64'd0, "unmapped_028");
        rd(1'b0, 12'h480, 64'd0, "a_out_of_range");

        // Reset mid-RUN
        wr(1'b0, OFF_LEN, 64'd16);
        start(1'b0, 64'd1, t0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_ready", 64'(io_cmd_ready_o), 64'd1);
        check("mid_rst_resp_v", 64'(io_resp_v_o), 64'd0);
        check("mid_rst_data", io_resp_data_o, 64'd0);
        check("mid_rst_done", 64'(done_o), 64'd0);
        #2;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i); #1;
        end
        check("post_rst_done", 64'(done_o), 64'd0);
        rd(1'b0, OFF_STAT, 64'd0, "post_rst_status0");
        rd(1'b0, OFF_RES, 64'd0, "post_rst_result0");
        rd(1'b1, OFF_STAT, 64'd0, "post_rst_status1");
        rd(1'b0, 12'h400, 64'd0, "post_rst_a0");

        // Drain scoreboard
        n = 0;
        while ((exp_q.size() != 0 || io_resp_v_o) && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
